// File: rtl/ins_fetch.sv
// Instruction fetch stage: loadable program RAM, opcode screen, and a 2-entry
// prefetch FIFO that hands {pc, word} to the execute stage.
module ins_fetch #(
  parameter int IW     = 20,
  parameter int AW     = 4,
  parameter int OP_MAX = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [IW-1:0] ld_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  output logic          ins_valid,
  input  logic          ins_ready,
  output logic [IW-1:0] ins_data,
  output logic [AW-1:0] ins_pc,
  output logic          busy,
  output logic          done,
  output logic          illegal
);

  localparam int DEPTH = 2**AW;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t state_q, state_d;

  logic [IW-1:0]    mem [DEPTH];
  logic [AW:0]      pc_q, len_q, pc_nxt;
  logic             rd_vld_q;
  logic [AW-1:0]    rd_pc_q;
  logic [IW-1:0]    rd_data_q;
  logic             illegal_q;
  logic [IW+AW-1:0] fifo_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       cnt_q;

  logic       idle_like, start_ok, ld_ok, push, pop, ret_bad, rd_issue;
  logic [3:0] ret_op;
  logic [2:0] occ;

  // Handshake: a word moves to the execute stage on a rising edge where
  // ins_valid & ins_ready; while ins_valid=1 & ins_ready=0 the FIFO head, and so
  // ins_data/ins_pc, cannot change, and ins_valid only falls after a transfer.
  assign idle_like = (state_q == IDLE) || (state_q == DONE);
  assign start_ok  = start && idle_like;
  assign ld_ok     = ld_en && idle_like;
  assign ret_op    = rd_data_q[IW-1 -: 4];
  assign ret_bad   = rd_vld_q && ((ret_op == 4'd0) || (ret_op > 4'(OP_MAX)));
  assign push      = rd_vld_q && !ret_bad && !illegal_q;
  assign pop       = ins_valid && ins_ready;
  assign pc_nxt    = pc_q + {{AW{1'b0}}, 1'b1};

  // Occupancy after this edge's pop; counting the pop keeps 1 word/cycle with
  // ins_ready high while still never holding more than 2 words plus reads.
  assign occ      = {1'b0, cnt_q} + {2'b00, rd_vld_q} - {2'b00, pop};
  assign rd_issue = (state_q == FETCH) && !ret_bad && !illegal_q && (occ < 3'd2);

  assign ins_valid = (cnt_q != 2'd0);
  assign ins_data  = ins_valid ? fifo_q[rd_ptr_q][IW+AW-1:AW] : '0;
  assign ins_pc    = ins_valid ? fifo_q[rd_ptr_q][AW-1:0] : '0;
  assign busy      = (state_q == FETCH) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign illegal   = illegal_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) state_d = (prog_len == '0) ? DONE : FETCH;
      end
      FETCH: begin
        if (ret_bad)                           state_d = DRAIN;
        else if (rd_issue && pc_nxt == len_q)  state_d = DRAIN;
      end
      DRAIN: begin
        if (!rd_vld_q && cnt_q == 2'd0) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      len_q     <= '0;
      rd_vld_q  <= 1'b0;
      rd_pc_q   <= '0;
      illegal_q <= 1'b0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      cnt_q     <= 2'd0;
    end else begin
      state_q  <= state_d;
      rd_vld_q <= rd_issue;
      if (rd_issue) begin
        rd_pc_q <= pc_q[AW-1:0];
        pc_q    <= pc_nxt;
      end
      if (start_ok) begin
        pc_q      <= '0;
        len_q     <= prog_len;
        illegal_q <= 1'b0;
      end else if (ret_bad) begin
        illegal_q <= 1'b1;
      end
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage without reset: program RAM, read data register and FIFO slots.
  always_ff @(posedge clk) begin
    if (ld_ok)    mem[ld_addr] <= ld_data;
    if (rd_issue) rd_data_q    <= mem[pc_q[AW-1:0]];
    if (push)     fifo_q[wr_ptr_q] <= {rd_data_q, rd_pc_q};
  end

endmodule

// File: tb/tb_ins_fetch.sv
// Bench for ins_fetch: directed program runs, scoreboard of expected {pc, word}
// pairs popped by a monitor on every handshake transfer.
module tb_ins_fetch;

  localparam int IW = 20;
  localparam int AW = 4;
  localparam int W  = IW + AW;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          ld_en     = 1'b0;
  logic [AW-1:0] ld_addr   = '0;
  logic [IW-1:0] ld_data   = '0;
  logic [AW:0]   prog_len  = '0;
  logic          start     = 1'b0;
  logic          ins_ready = 1'b0;
  logic          ins_valid;
  logic [IW-1:0] ins_data;
  logic [AW-1:0] ins_pc;
  logic          busy, done, illegal;

  logic [W-1:0]  exp_q[$];
  logic [IW-1:0] prog [16];
  int            n_vec    = 0;
  int            n_fail   = 0;
  int            rdy_mode = 0;
  logic          hold_vld = 1'b0;
  logic [W-1:0]  hold_w   = '0;

  ins_fetch #(.IW(IW), .AW(AW), .OP_MAX(12)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .prog_len  (prog_len),
    .start     (start),
    .ins_valid (ins_valid),
    .ins_ready (ins_ready),
    .ins_data  (ins_data),
    .ins_pc    (ins_pc),
    .busy      (busy),
    .done      (done),
    .illegal   (illegal)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // ready pattern: 0 = held low, 1 = held high, 2 = toggles every cycle
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       ins_ready = 1'b0;
      1:       ins_ready = 1'b1;
      default: ins_ready = ~ins_ready;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver tasks (all return 1 time unit after a rising edge)
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [AW-1:0] a, input logic [IW-1:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 16; i++) load_word(4'(i), prog[i]);
  endtask

  task automatic start_run(input logic [AW:0] len);
    prog_len = len; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic expect_words(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({4'(i), prog[i]});
  endtask

  task automatic wait_done(input string name, input int budget);
    int k;
    k = 0;
    while (done !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    check(name, 32'(done), 32'd1);
  endtask

  // Scoreboard monitor: transfers are decided on the coming edge, so sample here
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_vld = 1'b0;
    end else begin
      if (hold_vld) begin
        check("valid_held", 32'(ins_valid), 32'd1);
        if (ins_valid) check("stable_word", 32'({ins_pc, ins_data}), 32'(hold_w));
      end
      if (ins_valid && ins_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_word: got pc=%0d data=0x%0h expected none", ins_pc, ins_data);
        end else begin
          check("word", 32'({ins_pc, ins_data}), 32'(exp_q.pop_front()));
        end
        hold_vld = 1'b0;
      end else if (ins_valid) begin
        hold_vld = 1'b1;
        hold_w   = {ins_pc, ins_data};
      end else begin
        hold_vld = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) prog[i] = {4'((i % 12) + 1), 8'(i), 8'(8'hA0 + i)};

    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", 32'({ins_valid, ins_data, ins_pc, busy, done, illegal}), 32'd0);
    rst_n = 1'b1;
    tick();

    // T1: two-word program, ready high, exact timing
    load_word(4'd0, 20'h10102);
    load_word(4'd1, 20'h3010F);
    exp_q.push_back({4'd0, 20'h10102});
    exp_q.push_back({4'd1, 20'h3010F});
    rdy_mode = 1;
    tick();
    start_run(5'd2);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_valid_e0", 32'(ins_valid), 32'd0);
    tick();
    check("t1_valid_e1", 32'(ins_valid), 32'd0);
    tick();
    check("t1_first", 32'({ins_valid, ins_pc, ins_data}), 32'({1'b1, 4'd0, 20'h10102}));
    tick();
    check("t1_second", 32'({ins_valid, ins_pc, ins_data}), 32'({1'b1, 4'd1, 20'h3010F}));
    tick();
    check("t1_drained", 32'({ins_valid, done}), 32'd0);
    tick();
    check("t1_done", 32'(done), 32'd1);
    check("t1_q_empty", 32'(exp_q.size()), 32'd0);

    // T2: full 16-word program, toggling ready, pc wraps at 15
    load_prog();
    expect_words(16);
    rdy_mode = 2;
    start_run(5'd16);
    wait_done("t2_done", 200);
    check("t2_illegal", 32'(illegal), 32'd0);
    check("t2_q_empty", 32'(exp_q.size()), 32'd0);

    // T3: op 0xF at word 3 stops the run
    rdy_mode = 1;
    load_word(4'd3, 20'hF1234);
    expect_words(3);
    start_run(5'd8);
    wait_done("t3_done", 100);
    check("t3_illegal", 32'({illegal, busy}), 32'({1'b1, 1'b0}));
    check("t3_q_empty", 32'(exp_q.size()), 32'd0);

    // T3b: op 13 (just above the legal range) at word 1
    load_word(4'd3, prog[3]);
    load_word(4'd1, 20'hD0000);
    expect_words(1);
    start_run(5'd4);
    check("t3b_illegal_clr", 32'(illegal), 32'd0);
    wait_done("t3b_done", 100);
    check("t3b_illegal", 32'(illegal), 32'd1);
    check("t3b_q_empty", 32'(exp_q.size()), 32'd0);

    // T3c: op 0 at word 0, nothing delivered
    load_word(4'd1, prog[1]);
    load_word(4'd0, 20'h0ABCD);
    start_run(5'd4);
    wait_done("t3c_done", 100);
    check("t3c_illegal", 32'(illegal), 32'd1);
    check("t3c_q_empty", 32'(exp_q.size()), 32'd0);
    load_word(4'd0, prog[0]);

    // T4: ready low after start, FIFO fills and holds word 0, then no gap
    rdy_mode = 0;
    tick();
    expect_words(4);
    start_run(5'd4);
    repeat (10) tick();
    check("t4_hold", 32'({ins_valid, ins_pc, ins_data}), 32'({1'b1, 4'd0, prog[0]}));
    check("t4_busy", 32'(busy), 32'd1);
    @(negedge clk);
    rdy_mode = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t4_no_gap", 32'(ins_valid), 32'd1);
    end
    wait_done("t4_done", 50);
    check("t4_q_empty", 32'(exp_q.size()), 32'd0);

    // T5: asynchronous reset mid-run, then rerun from preserved RAM
    rdy_mode = 0;
    tick();
    expect_words(4);
    start_run(5'd4);
    tick();
    tick();
    check("t5_valid_before", 32'(ins_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_rst", 32'({ins_valid, ins_data, ins_pc, busy, done, illegal}), 32'd0);
    exp_q.delete();
    @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    check("t5_idle", 32'({ins_valid, busy, done, illegal}), 32'd0);
    expect_words(4);
    rdy_mode = 1;
    tick();
    start_run(5'd4);
    wait_done("t5_done", 50);
    check("t5_q_empty", 32'(exp_q.size()), 32'd0);

    // T6: zero-length program from IDLE, then load ignored during FETCH
    rdy_mode = 0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("t6_pre_done", 32'(done), 32'd0);
    start_run(5'd0);
    check("t6_len0_done", 32'({done, busy, ins_valid}), 32'({1'b1, 1'b0, 1'b0}));
    tick();
    check("t6_len0_no_valid", 32'(ins_valid), 32'd0);
    expect_words(4);
    start_run(5'd4);
    tick();
    check("t6_busy", 32'(busy), 32'd1);
    load_word(4'd0, 20'h5AAAA);
    @(negedge clk);
    rdy_mode = 1;
    wait_done("t6_run_done", 50);
    expect_words(2);
    start_run(5'd2);
    wait_done("t6_rerun_done", 50);
    check("t6_q_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
